pipe_stall_stage: RTL and testbench

Parametrised pipeline stage register that replaces the combinational stall select between two datapath stages. It holds a word when the downstream stage stalls, absorbs one extra in-flight word in a skid register so that `in_ready` is fully registered, and inserts a NOP bubble on flush. It also counts downstream stall cycles for performance monitoring. One instance sits on each inter-stage boundary of the processor pipeline.

---
 rtl/pipe_stall_stage.sv | 128 ++++++++++++
 tb/tb_pipe_stall_stage.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/pipe_stall_stage.sv
// Pipeline boundary register with a one-word skid buffer, flush-to-bubble and a
// saturating downstream stall counter. All outputs come straight from flops.
module pipe_stall_stage #(
   parameter int               WIDTH = 16,
   parameter logic [WIDTH-1:0] NOP   = {WIDTH{1'b0}},
   parameter int               CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   input  logic             flush,
   output logic [CNT_W-1:0] stall_cnt
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t           state_r;
   state_t           state_nxt_s;
   logic [WIDTH-1:0] main_r;
   logic [WIDTH-1:0] main_nxt_s;
   logic [WIDTH-1:0] skid_r;
   logic [WIDTH-1:0] skid_nxt_s;
   logic             out_valid_r;
   logic             in_ready_r;
   logic [CNT_W-1:0] stall_cnt_r;
   logic             accept_s;
   logic             deliver_s;
   logic             stall_s;

   assign accept_s  = in_valid & in_ready_r;
   assign deliver_s = out_valid_r & out_ready;
   assign stall_s   = out_valid_r & ~out_ready;

   // Next-state and storage update; flush overrides every other transition.
   always_comb begin
      state_nxt_s = state_r;
      main_nxt_s  = main_r;
      skid_nxt_s  = skid_r;
      if (flush) begin
         state_nxt_s = EMPTY;
         main_nxt_s  = NOP;
      end else begin
         case (state_r)
            EMPTY: begin
               if (accept_s) begin
                  state_nxt_s = ONE;
                  main_nxt_s  = in_data;
               end else begin
                  state_nxt_s = EMPTY;
               end
            end
            ONE: begin
               if (accept_s && deliver_s) begin
                  state_nxt_s = ONE;
                  main_nxt_s  = in_data;
               end else if (accept_s) begin
                  state_nxt_s = TWO;
                  skid_nxt_s  = in_data;
               end else if (deliver_s) begin
                  state_nxt_s = EMPTY;
                  main_nxt_s  = NOP;
               end else begin
                  state_nxt_s = ONE;
               end
            end
            TWO: begin
               // in_ready is low here, so only a delivery can move the state.
               if (deliver_s) begin
                  state_nxt_s = ONE;
                  main_nxt_s  = skid_r;
               end else begin
                  state_nxt_s = TWO;
               end
            end
            default: begin
               state_nxt_s = EMPTY;
               main_nxt_s  = NOP;
            end
         endcase
      end
   end

   // State, storage and handshake outputs registered from the next state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r     <= EMPTY;
         main_r      <= NOP;
         skid_r      <= NOP;
         out_valid_r <= 1'b0;
         in_ready_r  <= 1'b1;
      end else begin
         state_r     <= state_nxt_s;
         main_r      <= main_nxt_s;
         skid_r      <= skid_nxt_s;
         out_valid_r <= (state_nxt_s != EMPTY);
         in_ready_r  <= (state_nxt_s != TWO);
      end
   end

   // Saturating stall counter; only reset clears it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt_r <= {CNT_W{1'b0}};
      end else if (stall_s && (stall_cnt_r != CNT_MAX)) begin
         stall_cnt_r <= stall_cnt_r + CNT_ONE;
      end else begin
         stall_cnt_r <= stall_cnt_r;
      end
   end

   assign in_ready  = in_ready_r;
   assign out_data  = main_r;
   assign out_valid = out_valid_r;
   assign stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_pipe_stall_stage.sv
// Directed bench for pipe_stall_stage: a queue-based model checked every cycle,
// plus literal expectations for each scenario.
module tb_pipe_stall_stage;

   localparam int          WIDTH = 16;
   localparam int          CNT_W = 4;
   localparam int          CMAX  = (1 << CNT_W) - 1;
   localparam logic [15:0] NOPV  = 16'h0000;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [WIDTH-1:0]  in_data = '0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [WIDTH-1:0]  out_data;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic              flush = 1'b0;
   logic [CNT_W-1:0]  stall_cnt;

   int checks = 0;
   int failures = 0;

   logic [WIDTH-1:0] q[$];
   int               mcnt = 0;
   logic             mvld;
   logic             mrdy;

   pipe_stall_stage #(.WIDTH(WIDTH), .NOP(NOPV), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .flush     (flush),
      .stall_cnt (stall_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: the stage is a FIFO of at most two words between upstream and downstream.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         q.delete();
         mcnt = 0;
      end else begin
         mvld = (q.size() > 0);
         mrdy = (q.size() < 2);
         if (mvld && !out_ready && mcnt < CMAX) mcnt++;
         if (flush) begin
            q.delete();
         end else begin
            if (mvld && out_ready) void'(q.pop_front());
            if (in_valid && mrdy) q.push_back(in_data);
         end
      end
   end

   // Compare DUT against the model away from the active edge.
   always @(negedge clk) begin
      check("model_out_valid", {31'd0, out_valid}, {31'd0, (q.size() > 0)});
      check("model_out_data", {16'd0, out_data}, {16'd0, (q.size() > 0) ? q[0] : NOPV});
      check("model_in_ready", {31'd0, in_ready}, {31'd0, (q.size() < 2)});
      check("model_stall_cnt", {28'd0, stall_cnt}, mcnt);
   end

   task automatic step(input logic iv, input logic [15:0] d, input logic ordy, input logic fl);
      in_valid  = iv;
      in_data   = d;
      out_ready = ordy;
      flush     = fl;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #12;
      check("reset_out_valid", {31'd0, out_valid}, 32'd0);
      check("reset_out_data", {16'd0, out_data}, 32'd0);
      check("reset_in_ready", {31'd0, in_ready}, 32'd1);
      check("reset_stall_cnt", {28'd0, stall_cnt}, 32'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Streaming
      for (int i = 1; i <= 8; i++) begin
         step(1'b1, 16'(i), 1'b1, 1'b0);
         check("stream_data", {16'd0, out_data}, i);
         check("stream_valid", {31'd0, out_valid}, 32'd1);
         check("stream_in_ready", {31'd0, in_ready}, 32'd1);
      end
      step(1'b0, 16'h0000, 1'b1, 1'b0);
      check("stream_drain_valid", {31'd0, out_valid}, 32'd0);
      check("stream_stall_cnt", {28'd0, stall_cnt}, 32'd0);

      // Skid fill
      step(1'b1, 16'h00A1, 1'b1, 1'b0);
      check("skid_first", {16'd0, out_data}, 32'h00A1);
      step(1'b1, 16'h00A2, 1'b0, 1'b0);
      check("skid_hold1", {16'd0, out_data}, 32'h00A1);
      check("skid_in_ready1", {31'd0, in_ready}, 32'd0);
      step(1'b0, 16'h0000, 1'b0, 1'b0);
      check("skid_hold2", {16'd0, out_data}, 32'h00A1);
      step(1'b0, 16'h0000, 1'b0, 1'b0);
      check("skid_hold3", {16'd0, out_data}, 32'h00A1);
      check("skid_in_ready3", {31'd0, in_ready}, 32'd0);
      check("skid_stall_cnt", {28'd0, stall_cnt}, 32'd3);
      step(1'b0, 16'h0000, 1'b1, 1'b0);
      check("skid_second", {16'd0, out_data}, 32'h00A2);
      check("skid_in_ready_back", {31'd0, in_ready}, 32'd1);
      step(1'b0, 16'h0000, 1'b1, 1'b0);
      check("skid_empty", {31'd0, out_valid}, 32'd0);

      // Flush in TWO
      step(1'b1, 16'h00B1, 1'b0, 1'b0);
      step(1'b1, 16'h00B2, 1'b0, 1'b0);
      check("flush_pre_in_ready", {31'd0, in_ready}, 32'd0);
      step(1'b0, 16'h0000, 1'b0, 1'b1);
      check("flush_valid", {31'd0, out_valid}, 32'd0);
      check("flush_data", {16'd0, out_data}, 32'd0);
      check("flush_in_ready", {31'd0, in_ready}, 32'd1);
      step(1'b0, 16'h0000, 1'b1, 1'b0);
      check("flush_no_b2", {31'd0, out_valid}, 32'd0);
      check("flush_stall_cnt", {28'd0, stall_cnt}, 32'd5);

      // Flush with simultaneous accept
      step(1'b1, 16'h00C3, 1'b1, 1'b1);
      check("flush_acc_valid", {31'd0, out_valid}, 32'd0);
      step(1'b0, 16'h0000, 1'b1, 1'b0);
      check("flush_acc_valid2", {31'd0, out_valid}, 32'd0);

      // Counter saturation
      step(1'b1, 16'h00D1, 1'b0, 1'b0);
      for (int i = 0; i < 20; i++) step(1'b0, 16'h0000, 1'b0, 1'b0);
      check("sat_stall_cnt", {28'd0, stall_cnt}, 32'd15);
      check("sat_hold_data", {16'd0, out_data}, 32'h00D1);

      // Asynchronous reset while in TWO
      step(1'b1, 16'h00D2, 1'b0, 1'b0);
      check("arst_pre_in_ready", {31'd0, in_ready}, 32'd0);
      #2;
      rst = 1'b1;
      #1;
      check("arst_out_valid", {31'd0, out_valid}, 32'd0);
      check("arst_out_data", {16'd0, out_data}, 32'd0);
      check("arst_in_ready", {31'd0, in_ready}, 32'd1);
      check("arst_stall_cnt", {28'd0, stall_cnt}, 32'd0);
      #10;
      rst = 1'b0;
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      step(1'b1, 16'h00E1, 1'b1, 1'b0);
      check("post_reset_data", {16'd0, out_data}, 32'h00E1);
      step(1'b0, 16'h0000, 1'b1, 1'b0);
      step(1'b0, 16'h0000, 1'b1, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
